// File: rtl/fetch_unit.sv
// Instruction fetch initiator: sequential word reads into a prefetch FIFO, handed to decode via valid/ready.
// Latency: a fetched word is visible on instr_valid the cycle after its memory transfer completes.
// Backpressure: mem_cs drops while the FIFO is full; wait states (mem_ready low) hold mem_cs/mem_addr stable.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mem_cs, mem_addr              word read request to memory (mem_addr[1:0] always 0)
//   mem_rdata, mem_ready          read data and completion strobe from memory
//   instr_valid, instr_ready      decode handshake on the FIFO head
//   instr_data, instr_pc          head instruction word and the address it came from
//   redirect, redirect_pc         flush the FIFO and restart fetch at redirect_pc
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_cs,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [31:0]      WORD_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0]      RESET_PC_W = RESET_PC & WORD_MASK;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fifo_data_q [DEPTH];
    logic [31:0]        fifo_data_d [DEPTH];
    logic [31:0]        fifo_pc_q   [DEPTH];
    logic [31:0]        fifo_pc_d   [DEPTH];

    logic push;
    logic pop;

    // Request side depends only on registers and redirect, so a combinational
    // responder that feeds mem_ready back from mem_cs cannot form a loop.
    always_comb begin
        mem_cs      = (state_q == REQ) && (count_q < DEPTH_C) && !redirect;
        mem_addr    = fetch_pc_q;
        instr_valid = (count_q != '0);
        instr_data  = fifo_data_q[rd_ptr_q];
        instr_pc    = fifo_pc_q[rd_ptr_q];
        push        = mem_cs && mem_ready;
        pop         = instr_valid && instr_ready;
    end

    always_comb begin
        state_d     = REQ;
        fetch_pc_d  = fetch_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;

        if (redirect) begin
            // Flush wins over any same-cycle pop; push is already blocked via mem_cs.
            fetch_pc_d = redirect_pc & WORD_MASK;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fifo_data_d[wr_ptr_q] = mem_rdata;
                fifo_pc_d[wr_ptr_q]   = fetch_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                fetch_pc_d            = fetch_pc_q + 32'd4;  // wraps FFFF_FFFC -> 0
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC_W;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fifo_data_q <= '{default: '0};
            fifo_pc_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic against a queue-based model.
// Latency: model expects a word at the head the cycle after its transfer.
// Backpressure: random mem_ready / instr_ready stalls and random redirects.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_cs;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready   = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int total = 0;
    int bad   = 0;

    // Reference model: fetch address, running flag and a queue of fetched addresses.
    logic [31:0] m_pc;
    bit          m_running;
    logic [31:0] m_q[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_cs      (mem_cs),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // Memory contents: an arbitrary but fixed function of the word address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign mem_rdata = word_of(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc      = 32'h0;
        m_running = 1'b0;
    endtask

    // One clock cycle: apply inputs, check outputs against the model, advance the model.
    task automatic step(input logic rdy, input logic irdy, input logic redir, input logic [31:0] rpc);
        bit exp_cs;
        bit do_pop;
        bit do_push;
        mem_ready   = rdy;
        instr_ready = irdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        exp_cs = m_running && (m_q.size() < DEPTH) && !redir;
        chk("mem_cs", {31'b0, mem_cs}, {31'b0, exp_cs});
        chk("mem_addr", mem_addr, m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("instr_pc", instr_pc, m_q[0]);
            chk("instr_data", instr_data, word_of(m_q[0]));
        end
        if (redir) begin
            m_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            do_pop  = (m_q.size() != 0) && irdy;
            do_push = exp_cs && rdy;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        m_running = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        // Reset state
        chk("rst_mem_cs", {31'b0, mem_cs}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        rst = 1'b0;

        // 1: streaming with 1-cycle memory and always-ready consumer
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // 2: consumer stalled fills the FIFO, then a single pop admits one fetch
        step(1'b0, 1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_addr_held", mem_addr, 32'd16);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // 3: three wait states on address 8
        step(1'b0, 1'b1, 1'b1, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // 4: redirect with three queued words; low address bits dropped
        step(1'b0, 1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        chk("redir_addr", mem_addr, 32'h0000_0100);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // 5: address wrap at the top of the space
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // 6: reset during a wait state with two queued words
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mem_cs", {31'b0, mem_cs}, 32'h0);
        chk("midrst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r_rdy;
            logic        r_irdy;
            logic        r_redir;
            logic [31:0] r_pc;
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_irdy  = ($urandom_range(0, 2) != 0);
            r_redir = ($urandom_range(0, 19) == 0);
            r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
            step(r_rdy, r_irdy, r_redir, r_pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
